// File: rtl/sprite_scheduler_pkg.sv
// Shared sizes, fixed-point format and FSM states for the sprite scheduler.
// Distances are signed Q8.8 (FW bits, QN fraction bits).
package sprite_scheduler_pkg;

    localparam int SPRITE_SLOTS = 8;
    localparam int SPRITE_IDXW  = 3;
    localparam int SPRITE_COLW  = 11;
    localparam int FW           = 16;
    localparam int QN           = 8;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SCAN,
        ST_SCAN_LAST,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// Sprite entry stream: valid/ready handshake carrying distance and column.
// The tracer side uses slave; the renderer side uses master.
interface sprite_scheduler_if
    import sprite_scheduler_pkg::*;
#(
    parameter int COLW = SPRITE_COLW
);

    logic                   valid;
    logic                   ready;
    logic signed [FW-1:0]   sdist;
    logic [COLW-1:0]        scol;
    logic [SPRITE_IDXW-1:0] index;
    logic                   last;

    modport master (
        output valid, sdist, scol, index, last,
        input  ready
    );

    modport slave (
        input  valid, sdist, scol,
        output ready
    );

endinterface

// File: rtl/sprite_scheduler.sv
// Loads sprite entries into the buffer, then replays them far-to-near
// by repeated max-distance scans with a one-cycle read pipeline.
module sprite_scheduler
    import sprite_scheduler_pkg::*;
#(
    parameter int SLOTS = SPRITE_SLOTS,
    parameter int COLW  = SPRITE_COLW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sprite_scheduler_if.slave      s,
    input  logic                   sort_go,
    sprite_scheduler_if.master     m,
    output logic                   busy,
    output logic                   done,
    output logic                   buf_we,
    output logic                   buf_oe,
    output logic [SPRITE_IDXW-1:0] buf_index,
    output logic signed [FW-1:0]   buf_sdist_wr,
    output logic [COLW-1:0]        buf_scol_wr,
    input  logic signed [FW-1:0]   buf_sdist_rd,
    input  logic [COLW-1:0]        buf_scol_rd
);

    state_t state, state_n;

    logic [3:0]             count;
    logic [3:0]             remaining;
    logic [3:0]             rem_n;
    logic [SLOTS-1:0]       used;
    logic [SPRITE_IDXW-1:0] ptr;
    logic                   accept;
    logic                   pos;

    logic                   cand_v;
    logic signed [FW-1:0]   cand_d;
    logic [COLW-1:0]        cand_c;
    logic [SPRITE_IDXW-1:0] cand_i;

    logic                   best_v;
    logic signed [FW-1:0]   best_d;
    logic [COLW-1:0]        best_c;
    logic [SPRITE_IDXW-1:0] best_i;

    logic                   upd;
    logic signed [FW-1:0]   nb_d;
    logic [COLW-1:0]        nb_c;
    logic [SPRITE_IDXW-1:0] nb_i;

    logic                   mv_q;
    logic signed [FW-1:0]   md_q;
    logic [COLW-1:0]        mc_q;
    logic [SPRITE_IDXW-1:0] mi_q;
    logic                   ml_q;

    assign busy    = (state != ST_LOAD);
    assign done    = (state == ST_DONE);
    assign m.valid = mv_q;
    assign m.sdist = md_q;
    assign m.scol  = mc_q;
    assign m.index = mi_q;
    assign m.last  = ml_q;

    // Running-max comparator: strict greater keeps the lower index on ties.
    always_comb begin
        upd  = cand_v && !used[cand_i] && (!best_v || cand_d > best_d);
        nb_d = upd ? cand_d : best_d;
        nb_c = upd ? cand_c : best_c;
        nb_i = upd ? cand_i : best_i;
    end

    // Next-state and buffer/stream control.
    always_comb begin
        state_n      = state;
        s.ready      = 1'b0;
        accept       = 1'b0;
        pos          = 1'b0;
        buf_we       = 1'b0;
        buf_oe       = 1'b0;
        buf_index    = '0;
        buf_sdist_wr = '0;
        buf_scol_wr  = '0;
        rem_n        = remaining;
        unique case (state)
            ST_LOAD: begin
                s.ready   = (count < 4'(SLOTS));
                accept    = s.valid && s.ready;
                pos       = accept && (s.sdist > 0);
                rem_n     = remaining + {3'b0, pos};
                buf_we    = accept;
                buf_index = count[SPRITE_IDXW-1:0];
                if (accept) begin
                    buf_sdist_wr = s.sdist;
                    buf_scol_wr  = s.scol;
                end
                if (sort_go)
                    state_n = (rem_n == 4'd0) ? ST_DONE : ST_SCAN;
            end
            ST_SCAN: begin
                buf_oe    = 1'b1;
                buf_index = ptr;
                if ({1'b0, ptr} == count - 4'd1)
                    state_n = ST_SCAN_LAST;
            end
            ST_SCAN_LAST: state_n = ST_EMIT;
            ST_EMIT: begin
                if (m.ready)
                    state_n = (remaining == 4'd1) ? ST_DONE : ST_SCAN;
            end
            ST_DONE: state_n = ST_LOAD;
            default: state_n = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_LOAD;
        else          state <= state_n;
    end

    // Counters, consumed mask, read pipeline and emitted entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            remaining <= '0;
            used      <= '0;
            ptr       <= '0;
            cand_v    <= 1'b0;
            cand_d    <= '0;
            cand_c    <= '0;
            cand_i    <= '0;
            best_v    <= 1'b0;
            best_d    <= '0;
            best_c    <= '0;
            best_i    <= '0;
            mv_q      <= 1'b0;
            md_q      <= '0;
            mc_q      <= '0;
            mi_q      <= '0;
            ml_q      <= 1'b0;
        end else begin
            cand_v <= (state == ST_SCAN);
            cand_d <= buf_sdist_rd;
            cand_c <= buf_scol_rd;
            cand_i <= ptr;
            unique case (state)
                ST_LOAD: begin
                    remaining <= rem_n;
                    if (accept) begin
                        count <= count + 4'd1;
                        if (!pos) used[count[SPRITE_IDXW-1:0]] <= 1'b1;
                    end
                    ptr    <= '0;
                    best_v <= 1'b0;
                end
                ST_SCAN: begin
                    ptr    <= ptr + 1'b1;
                    best_v <= best_v | upd;
                    best_d <= nb_d;
                    best_c <= nb_c;
                    best_i <= nb_i;
                end
                ST_SCAN_LAST: begin
                    mv_q <= 1'b1;
                    md_q <= nb_d;
                    mc_q <= nb_c;
                    mi_q <= nb_i;
                    ml_q <= (remaining == 4'd1);
                end
                ST_EMIT: begin
                    if (m.ready) begin
                        mv_q       <= 1'b0;
                        used[mi_q] <= 1'b1;
                        remaining  <= remaining - 4'd1;
                        ptr        <= '0;
                        best_v     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    count     <= '0;
                    used      <= '0;
                    remaining <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: directed frames with hand-computed
// painter's-order emissions; a negedge monitor checks every handshake.
module tb_sprite_scheduler;
    import sprite_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sort_go = 1'b0;
    logic busy, done, buf_we, buf_oe;
    logic [2:0] buf_index;
    logic signed [15:0] buf_sdist_wr, buf_sdist_rd;
    logic [10:0] buf_scol_wr, buf_scol_rd;

    sprite_scheduler_if s_if ();
    sprite_scheduler_if m_if ();

    assign s_if.index = '0;
    assign s_if.last  = 1'b0;

    sprite_scheduler dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .s            (s_if),
        .sort_go      (sort_go),
        .m            (m_if),
        .busy         (busy),
        .done         (done),
        .buf_we       (buf_we),
        .buf_oe       (buf_oe),
        .buf_index    (buf_index),
        .buf_sdist_wr (buf_sdist_wr),
        .buf_scol_wr  (buf_scol_wr),
        .buf_sdist_rd (buf_sdist_rd),
        .buf_scol_rd  (buf_scol_rd)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mem_d [8];
    logic [10:0]        mem_c [8];

    always @(posedge clk) begin
        if (buf_we) begin
            mem_d[buf_index] <= buf_sdist_wr;
            mem_c[buf_index] <= buf_scol_wr;
        end
    end

    assign buf_sdist_rd = buf_oe ? mem_d[buf_index] : '0;
    assign buf_scol_rd  = buf_oe ? mem_c[buf_index] : '0;

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] c;
        logic [2:0]  i;
        logic        l;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int c, input int i, input bit l);
        exp_t e;
        e.d = 16'(d);
        e.c = 11'(c);
        e.i = 3'(i);
        e.l = l;
        q.push_back(e);
    endtask

    // Scoreboard monitor: pop and compare on every renderer handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (buf_we && buf_oe) begin
                tests++;
                fails++;
                $display("FAIL we_oe_both: we=1 oe=1 required not both");
            end
            if (m_if.valid && m_if.ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL emit_unexpected: idx=%0d with empty queue", m_if.index);
                end else begin
                    e = q.pop_front();
                    chk("emit_sdist", longint'(m_if.sdist), longint'($signed(e.d)));
                    chk("emit_scol", m_if.scol, e.c);
                    chk("emit_index", m_if.index, e.i);
                    chk("emit_last", m_if.last, e.l);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int c, input bit rdy, input bit go);
        s_if.valid = 1'b1;
        s_if.sdist = 16'(d);
        s_if.scol  = 11'(c);
        sort_go    = go;
        @(negedge clk);
        chk("s_ready", s_if.ready, rdy);
        tick();
        s_if.valid = 1'b0;
        sort_go    = 1'b0;
    endtask

    task automatic run_frame(input bit go, input int lat);
        int c;
        bit seen;
        bit fin;
        sort_go = go;
        c = 0;
        seen = 0;
        fin = 0;
        while (!fin && c < 400) begin
            @(negedge clk);
            if (!seen && m_if.valid) begin
                seen = 1;
                if (lat >= 0) chk("first_valid_cycle", c, lat);
            end
            if (m_if.valid && m_if.ready && m_if.last) begin
                @(negedge clk);
                chk("done_after_last", done, 1);
                @(negedge clk);
                chk("done_pulse_len", done, 0);
                chk("s_ready_after_done", s_if.ready, 1);
                fin = 1;
            end else if (done) begin
                if (!seen && lat >= 0) chk("empty_done_cycle", c, lat);
                @(negedge clk);
                chk("s_ready_after_done", s_if.ready, 1);
                fin = 1;
            end
            tick();
            sort_go = 1'b0;
            c++;
        end
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: got %0d cycles required done", c);
        end
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        s_if.valid = 1'b0;
        s_if.sdist = '0;
        s_if.scol  = '0;
        m_if.ready = 1'b1;
        #12;
        chk("rst_s_ready", s_if.ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_we", buf_we, 0);
        chk("rst_oe", buf_oe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 3.0, 7.5, 1.25 -> idx 1, 0, 2
        push(1920, 200, 1, 0);
        push(768, 100, 0, 0);
        push(320, 300, 2, 1);
        send(768, 100, 1, 0);
        send(1920, 200, 1, 0);
        send(320, 300, 1, 0);
        run_frame(1, 5);

        // 10 offered, 8 accepted
        push(2048, 60, 6, 0);
        push(1536, 10, 1, 0);
        push(1536, 30, 3, 0);
        push(1024, 70, 7, 0);
        push(896, 40, 4, 0);
        push(512, 0, 0, 0);
        push(256, 20, 2, 0);
        push(128, 50, 5, 1);
        send(512, 0, 1, 0);
        send(1536, 10, 1, 0);
        send(256, 20, 1, 0);
        send(1536, 30, 1, 0);
        send(896, 40, 1, 0);
        send(128, 50, 1, 0);
        send(2048, 60, 1, 0);
        send(1024, 70, 1, 0);
        send(2304, 80, 0, 0);
        send(2432, 90, 0, 0);
        run_frame(1, 10);

        // -2.0, 0, 4.0 -> only idx 2; sort_go with the last entry
        push(1024, 33, 2, 1);
        send(-512, 11, 1, 0);
        send(0, 22, 1, 0);
        send(1024, 33, 1, 1);
        run_frame(0, 4);

        // tie at 5.0 in slots 3 and 6
        push(1280, 103, 3, 0);
        push(1280, 106, 6, 0);
        push(768, 104, 4, 0);
        push(512, 101, 1, 0);
        push(256, 100, 0, 0);
        push(128, 102, 2, 1);
        send(256, 100, 1, 0);
        send(512, 101, 1, 0);
        send(128, 102, 1, 0);
        send(1280, 103, 1, 0);
        send(768, 104, 1, 0);
        send(-256, 105, 1, 0);
        send(1280, 106, 1, 0);
        run_frame(1, 9);

        // stall the renderer for 20 cycles
        m_if.ready = 1'b0;
        push(768, 6, 1, 0);
        push(512, 5, 0, 1);
        send(512, 5, 1, 0);
        send(768, 6, 1, 0);
        sort_go = 1'b1;
        begin
            int c;
            c = 0;
            while (c < 50) begin
                @(negedge clk);
                if (m_if.valid) break;
                tick();
                sort_go = 1'b0;
                c++;
            end
            chk("stall_first_valid", c, 4);
        end
        tick();
        sort_go = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("stall_valid", m_if.valid, 1);
            chk("stall_sdist", longint'(m_if.sdist), 768);
            chk("stall_scol", m_if.scol, 6);
            chk("stall_index", m_if.index, 1);
            chk("stall_oe", buf_oe, 0);
            tick();
        end
        m_if.ready = 1'b1;
        run_frame(0, -1);

        // reset in the middle of a scan
        send(256, 1, 1, 0);
        send(512, 2, 1, 0);
        send(768, 3, 1, 0);
        send(1024, 4, 1, 0);
        sort_go = 1'b1;
        tick();
        sort_go = 1'b0;
        tick();
        chk("scan_busy", busy, 1);
        chk("scan_oe", buf_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", buf_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", s_if.ready, 1);
        chk("mid_rst_m_valid", m_if.valid, 0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_s_ready", s_if.ready, 1);
        run_frame(1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Sequencer for the 8-slot `sprite_buffer`. During vblank it accepts the tracer's sprite entries (distance plus screen column) over a valid/ready stream and writes them into consecutive buffer slots. On `sort_go` it replays them far-to-near (painter's order) to the sprite renderer by repeated max-distance scans through the buffer's read port. It is the only master of the buffer's `we`/`oe`/`index` pins; the parent owns the tri-state join.

## Interface
Parameters:
- `SLOTS`, 8: buffer depth; index width is 3.
- `COLW`, 11: screen-column width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  tracer entry valid.
- `s_ready`  out  1  entry accepted when `s_valid && s_ready`.
- `s_sdist`  in  `F`  signed Qmn sprite distance.
- `s_scol`  in  COLW  sprite centre column.
- `sort_go`  in  1  single-cycle pulse; starts emission.
- `m_valid`  out  1  emitted entry valid; held until `m_ready`.
- `m_ready`  in  1  renderer accepts the entry.
- `m_sdist`  out  `F`  emitted distance.
- `m_scol`  out  COLW  emitted column.
- `m_index`  out  3  source slot of the emitted entry.
- `m_last`  out  1  final emitted entry of the frame.
- `busy`  out  1  high in every state except LOAD.
- `done`  out  1  one-cycle pulse when the frame's list is exhausted.
- `buf_we`, `buf_oe`  out  1  buffer enables; never both high.
- `buf_index`  out  3  buffer slot.
- `buf_sdist_wr`, `buf_scol_wr`  out  `F`/COLW  write data. The parent drives the buffer bus with these when `buf_we`=1.
- `buf_sdist_rd`, `buf_scol_rd`  in  `F`/COLW  buffer read data.

## Operation
- States: LOAD (reset state), SCAN, SCAN_LAST, EMIT, DONE.
- Registers:
  - `count` (0..8): slots written.
  - `used[7:0]`: slot consumed or rejected.
  - `remaining` (0..8): entries still to emit.
  - `best_*`: running maximum of the current scan.
- LOAD: `s_ready = (count < 8)`.
  - On handshake: `buf_we` = 1 combinationally, `buf_index = count`, write data = `s_*`, then `count++`.
  - An entry with `s_sdist` ≤ 0 (at or behind the viewer) is written but sets `used[count]`. Otherwise `remaining++`.
- `sort_go` is honoured only in LOAD. If it coincides with an accepted entry, that entry is included.
  - `remaining` = 0 → DONE.
  - Otherwise → SCAN with pointer 0 and best invalid.
- SCAN: `buf_oe` = 1, `buf_index = pointer`, pointer++ each cycle for `count` cycles, then → SCAN_LAST.
  - Data for the pointer issued in cycle k arrives in cycle k+1 and is compared then.
  - A candidate replaces best if it is not `used` and (best is invalid or its signed sdist > best sdist, strictly). On ties the lower index wins.
- SCAN_LAST: compare the final read. → EMIT with `m_*` = best, `m_last = (remaining == 1)`.
- EMIT: hold `m_valid` and data stable until `m_ready`. On handshake: set `used[m_index]`, `remaining--`.
  - Remaining still > 0 → SCAN.
  - Otherwise → DONE.
- DONE: `done` = 1 for one cycle. Clear `count`, `used`, `remaining`; `s_ready` = 0. → LOAD.
- Reset (asserted at any time, including mid-scan or mid-EMIT) immediately returns to LOAD.
  - Reset values: `s_ready`=1; all other outputs 0; all counters and mask 0.
  - Buffer contents are not cleared; they are harmless because `count` = 0.

## Timing
- Load: one entry per cycle; the buffer write commits on the same edge as the handshake.
- With `sort_go` high in cycle 0 and n = `count`:
  - SCAN occupies cycles 1..n.
  - SCAN_LAST is cycle n+1.
  - `m_valid` rises in cycle n+2.
- After an EMIT handshake in cycle t, the next `m_valid` rises in cycle t+n+2. n stays fixed for the frame.
- From the final handshake in cycle t: `done` in cycle t+1, `s_ready` high again in cycle t+2.
- `sort_go` with no accepted entries: `done` in cycle 1.
- `m_ready` high while `m_valid` is low has no effect.

## Structure
- Shared include `sprite_params.v` holds `SPRITE_SLOTS`=8, `SPRITE_IDXW`=3, `SPRITE_COLW`=11, and the state encodings.
- `F`/Qmn come from `fixed_point_params.v`.
- No sub-module: a flat FSM with a pipelined comparator. The parent instantiates `sprite_buffer` and the tri-state join.

## Test plan
- Load distances 3.0, 7.5, 1.25 (columns 100, 200, 300), then `sort_go` → emits idx 1, 0, 2 in that order. `m_valid` first rises 5 cycles after `sort_go`. `m_last` is set only on idx 2. `done` follows one cycle after the last handshake.
- Offer 10 entries back-to-back → first 8 accepted. `s_ready` drops after the 8th handshake. Emission yields 8 entries in strictly non-increasing distance order.
- Load distances −2.0, 0, 4.0 → only idx 2 is emitted, with `m_last`=1.
- Equal distances 5.0 in slots 3 and 6 → slot 3 is emitted before slot 6.
- Hold `m_ready` low for 20 cycles → `m_valid`, `m_sdist`, `m_scol`, `m_index` stay stable. `buf_oe` stays 0.
- Assert `reset_n` low mid-SCAN → `buf_oe`=0 and `busy`=0 immediately. After release, `s_ready`=1 and an empty `sort_go` produces `done` in cycle 1.
